// File: rtl/dadda_seq_mult16_if.sv
// Operand/result handshake bundle for the folded 16x16 multiplier.
// The master side is the producer/consumer pair; the slave side is the multiplier.
interface dadda_seq_mult16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/dadda_seq_mult16.sv
// Folded 16x16 unsigned multiplier: one 8x8 Dadda core reused over four steps,
// with the partial products accumulated into a registered 32-bit product.

module dadda_8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    localparam int unsigned W    = 8;
    localparam int unsigned COLS = 2 * W;

    logic            col  [COLS][W];
    logic            ncol [COLS][W];
    int              cnt  [COLS];
    int              ncnt [COLS];
    logic [COLS-1:0] row0;
    logic [COLS-1:0] row1;
    logic            fa_s;
    logic            fa_c;
    int              idx;
    int              avail;
    int              excess;
    int              d;

    // Column reduction with Dadda height targets 6,4,3,2, then one carry-propagate add.
    always_comb begin
        fa_s   = 1'b0;
        fa_c   = 1'b0;
        idx    = 0;
        avail  = 0;
        excess = 0;
        d      = 0;
        for (int c = 0; c < COLS; c++) begin
            cnt[c]  = 0;
            ncnt[c] = 0;
            for (int j = 0; j < W; j++) begin
                col[c][j]  = 1'b0;
                ncol[c][j] = 1'b0;
            end
        end
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                col[4'(i + j)][3'(cnt[4'(i + j)])] = a_i[i] & b_i[j];
                cnt[4'(i + j)] = cnt[4'(i + j)] + 1;
            end
        end
        for (int st = 0; st < 4; st++) begin
            d = (st == 0) ? 6 : (st == 1) ? 4 : (st == 2) ? 3 : 2;
            for (int c = 0; c < COLS; c++) begin
                ncnt[c] = 0;
                for (int j = 0; j < W; j++) ncol[c][j] = 1'b0;
            end
            for (int c = 0; c < COLS; c++) begin
                idx = 0;
                for (int k = 0; k < 4; k++) begin
                    avail  = cnt[c] - idx;
                    excess = avail + ncnt[c] - d;
                    if (excess >= 2 && avail >= 3) begin
                        fa_s = col[c][3'(idx)] ^ col[c][3'(idx + 1)] ^ col[c][3'(idx + 2)];
                        fa_c = (col[c][3'(idx)] & col[c][3'(idx + 1)])
                             | (col[c][3'(idx)] & col[c][3'(idx + 2)])
                             | (col[c][3'(idx + 1)] & col[c][3'(idx + 2)]);
                        idx  = idx + 3;
                    end else if (excess >= 1 && avail >= 2) begin
                        fa_s = col[c][3'(idx)] ^ col[c][3'(idx + 1)];
                        fa_c = col[c][3'(idx)] & col[c][3'(idx + 1)];
                        idx  = idx + 2;
                    end else begin
                        continue;
                    end
                    ncol[c][3'(ncnt[c])] = fa_s;
                    ncnt[c] = ncnt[c] + 1;
                    if (c < COLS - 1) begin
                        ncol[4'(c + 1)][3'(ncnt[4'(c + 1)])] = fa_c;
                        ncnt[4'(c + 1)] = ncnt[4'(c + 1)] + 1;
                    end
                end
                for (int j = 0; j < W; j++) begin
                    if (j >= idx && j < cnt[c]) begin
                        ncol[c][3'(ncnt[c])] = col[c][j];
                        ncnt[c] = ncnt[c] + 1;
                    end
                end
            end
            col = ncol;
            cnt = ncnt;
        end
        for (int c = 0; c < COLS; c++) begin
            row0[c] = col[c][0];
            row1[c] = col[c][1];
        end
        p_o = row0 + row1;
    end
endmodule

module dadda_seq_mult16 #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    dadda_seq_mult16_if.slave   bus_if
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] p_q, p_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] ra_q, ra_d;
    logic [15:0] rb_q, rb_d;
    logic [7:0]  core_a, core_b;
    logic [15:0] pp;
    logic [31:0] term;

    // Step bit 0 selects the high byte of ra, step bit 1 the high byte of rb.
    always_comb begin
        core_a = step_q[0] ? ra_q[15:8] : ra_q[7:0];
        core_b = step_q[1] ? rb_q[15:8] : rb_q[7:0];
        unique case (step_q)
            2'd0:    term = 32'(pp);
            2'd3:    term = 32'(pp) << 16;
            default: term = 32'(pp) << 8;
        endcase
    end

    dadda_8 u_core (
        .a_i (core_a),
        .b_i (core_b),
        .p_o (pp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            acc_q       <= 32'd0;
            p_q         <= 32'd0;
            out_valid_q <= 1'b0;
            ra_q        <= 16'd0;
            rb_q        <= 16'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        acc_d       = acc_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        unique case (state_q)
            IDLE: begin
                if (bus_if.in_valid) begin
                    ra_d   = bus_if.a;
                    rb_d   = bus_if.b;
                    acc_d  = 32'd0;
                    step_d = 2'd0;
                    if (SKIP_ZERO && (bus_if.a == 16'd0 || bus_if.b == 16'd0)) begin
                        p_d         = 32'd0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d  = acc_q + term;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    p_d         = acc_q + term;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && bus_if.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_if.in_ready  = (state_q == IDLE);
    assign bus_if.busy      = (state_q != IDLE);
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.p         = p_q;
endmodule

// File: tb/tb_dadda_seq_mult16.sv
// Scoreboard bench for dadda_seq_mult16: products queued at accept, compared at handshake.
module tb_dadda_seq_mult16;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dadda_seq_mult16_if bus0 ();
    dadda_seq_mult16_if bus1 ();

    dadda_seq_mult16 #(.SKIP_ZERO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus_if(bus0.slave));
    dadda_seq_mult16 #(.SKIP_ZERO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus_if(bus1.slave));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc   = 0;
    int          n_out   = 0;
    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Accept pushes the reference product; output handshake pops and compares.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.in_valid && bus0.in_ready) begin
                sb.push_back(32'(bus0.a) * 32'(bus0.b));
                n_acc++;
            end
            if (bus0.out_valid && bus0.out_ready) begin
                n_out++;
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("sb_p", bus0.p, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        int lat;
        lat = 0;
        while (!bus0.in_ready && lat < 20) begin step(); lat++; end
        check("idle_before_send", 32'(bus0.in_ready), 32'd1);
        bus0.a = a; bus0.b = b; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin step(); lat++; end
        check("latency", 32'(lat), 32'd4);
        check("p_direct", bus0.p, exp);
        step();
    endtask

    int pv_out, cyc, acc0, out0, lat1;

    initial begin
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.a = 16'd0; bus0.b = 16'd0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = 16'd0; bus1.b = 16'd0; bus1.out_ready = 1'b1;
        step(); step();
        check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("rst_p", bus0.p, 32'd0);
        rst = 1'b0;
        step();

        // Directed latency walk for 0x1234 * 0x5678.
        bus0.a = 16'h1234; bus0.b = 16'h5678; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        check("accept_in_ready", 32'(bus0.in_ready), 32'd0);
        check("accept_busy", 32'(bus0.busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("early_valid", 32'(bus0.out_valid), 32'd0);
        end
        step();
        check("e4_valid", 32'(bus0.out_valid), 32'd1);
        check("e4_p", bus0.p, 32'h0626_0060);
        step();
        check("e5_in_ready", 32'(bus0.in_ready), 32'd1);
        check("e5_valid", 32'(bus0.out_valid), 32'd0);

        run_pair(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_pair(16'h00FF, 16'hFF00, 32'h00FE_0100);
        run_pair(16'h8000, 16'h0002, 32'h0001_0000);

        // Backpressure with an ignored in_valid pulse during DONE.
        bus0.out_ready = 1'b0;
        pv_out = n_out;
        bus0.a = 16'h00FF; bus0.b = 16'h0101; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        lat1 = 0;
        while (!bus0.out_valid && lat1 < 20) begin step(); lat1++; end
        check("bp_latency", 32'(lat1), 32'd4);
        for (int i = 0; i < 3; i++) begin
            bus0.a = 16'd5; bus0.b = 16'd5; bus0.in_valid = (i == 1);
            step();
            check("bp_valid", 32'(bus0.out_valid), 32'd1);
            check("bp_p", bus0.p, 32'h0000_FFFF);
            check("bp_in_ready", 32'(bus0.in_ready), 32'd0);
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(bus0.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus0.in_ready), 32'd1);
        step(); step();
        check("bp_no_dup", 32'(n_out - pv_out), 32'd1);

        // Asynchronous reset during CALC step 2.
        bus0.a = 16'h1111; bus0.b = 16'h2222; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        check("arst_p", bus0.p, 32'd0);
        check("arst_valid", 32'(bus0.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus0.in_ready), 32'd1);
        check("arst_busy", 32'(bus0.busy), 32'd0);
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            check("arst_hold_valid", 32'(bus0.out_valid), 32'd0);
        end
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(bus0.in_ready), 32'd1);
        run_pair(16'd3, 16'd5, 32'd15);

        // SKIP_ZERO instance: normal pair, then the zero bypass.
        bus1.a = 16'd7; bus1.b = 16'd9; bus1.in_valid = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("skip_nz_early", 32'(bus1.out_valid), 32'd0);
        end
        step();
        check("skip_nz_valid", 32'(bus1.out_valid), 32'd1);
        check("skip_nz_p", bus1.p, 32'd63);
        step();
        bus1.a = 16'h0000; bus1.b = 16'hABCD; bus1.in_valid = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        check("skip_z_valid", 32'(bus1.out_valid), 32'd1);
        check("skip_z_p", bus1.p, 32'd0);
        step();
        check("skip_z_idle", 32'(bus1.in_ready), 32'd1);
        run_pair(16'h0000, 16'hABCD, 32'd0);

        // Random regression with gaps on both handshakes.
        acc0 = n_acc; out0 = n_out; cyc = 0;
        while (n_acc < acc0 + 1000 && cyc < 40000) begin
            bus0.in_valid  = ($urandom_range(0, 3) != 0);
            bus0.a         = 16'($urandom);
            bus0.b         = 16'($urandom);
            bus0.out_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        while (sb.size() != 0 && cyc < 40100) begin step(); cyc++; end
        step();
        check("rand_accepts", 32'(n_acc - acc0), 32'd1000);
        check("rand_outputs", 32'(n_out - out0), 32'd1000);
        check("rand_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
